oddrx4_tx_sequencer: RTL
========================

Name: oddrx4_tx_sequencer

Overview:
- SCLK-domain controller that sequences an 8:1 output gearbox. The gearbox takes 8 parallel bits per SCLK, is clocked by ECLK at 4x SCLK, and emits DDR output.
- Owns the gearbox reset and holds it until ECLK/SCLK lock is stable.
- After release, waits out the gearbox pipeline, then sends a training pattern.
- Then streams user words over a valid/ready handshake and inserts an idle pattern when no data is offered.
- Sits between the TX framing logic and the gearbox primitive.

Parameters:
- LOCK_WAIT, 16: consecutive SCLK cycles with lock_i=1 required before gear_rst_o is released (1..255).
- FLUSH_CYCLES, 4: SCLK cycles after release before the first meaningful word (1..15).
- TRAIN_WORDS, 8: number of training words sent (1..255).
- TRAIN_PATTERN, 8'hB4: training word; bit 0 maps to gearbox D0 (first bit out).
- IDLE_PATTERN, 8'h00: word driven when no transfer occurs.

Ports:
- SCLK, input, 1: system (slow) clock; every flop is on its rising edge.
- RSTB, input, 1: reset, synchronous, active-high.
- lock_i, input, 1: clock-source lock, already synchronised to SCLK.
- retrain_i, input, 1: single-cycle request to resend training.
- data_i, input, 8: user word; bit n goes to gearbox Dn.
- valid_i, input, 1: data_i is valid.
- ready_o, output, 1: sequencer accepts data_i this cycle.
- gear_rst_o, output, 1: gearbox RST, active-high.
- gear_d_o, output, 8: gearbox D0..D7, registered.
- state_o, output, 2: 0=HOLD, 1=FLUSH, 2=TRAIN, 3=RUN.
- link_up_o, output, 1: high while in RUN.
- word_cnt_o, output, 16: count of accepted user words; wraps modulo 2^16.

Behaviour:
- Reset (RSTB=1 at an SCLK edge), applied next edge:
  - state=HOLD, gear_rst_o=1, gear_d_o=IDLE_PATTERN, ready_o=0, link_up_o=0, word_cnt_o=0.
  - All internal counters cleared.
- HOLD:
  - gear_rst_o=1, gear_d_o=IDLE_PATTERN.
  - lock counter increments while lock_i=1 and clears to 0 on any cycle with lock_i=0.
  - On the edge where the counter reaches LOCK_WAIT-1 with lock_i=1: go to FLUSH and clear gear_rst_o on that same edge.
  - With LOCK_WAIT=16, lock_i high from cycle 0 means gear_rst_o falls at edge 16.
- FLUSH:
  - gear_rst_o=0, gear_d_o=IDLE_PATTERN.
  - Count FLUSH_CYCLES edges, then go to TRAIN.
- TRAIN:
  - gear_d_o=TRAIN_PATTERN for exactly TRAIN_WORDS consecutive cycles, then go to RUN.
  - retrain_i is ignored here.
- RUN:
  - ready_o=1 combinationally whenever state=RUN and retrain_i=0.
  - Transfer when valid_i & ready_o: gear_d_o<=data_i on the same edge, so latency is 1 SCLK from the handshake to the gearbox input. word_cnt_o increments by 1.
  - When no transfer occurs, gear_d_o<=IDLE_PATTERN.
  - link_up_o=1.
- Retrain:
  - retrain_i=1 in RUN: no transfer that cycle (ready_o=0); next state TRAIN with the train counter reset to 0.
  - gear_rst_o stays 0 and word_cnt_o is held.
- Lock loss:
  - lock_i=0 in FLUSH, TRAIN or RUN: next edge goes to HOLD, gear_rst_o=1, gear_d_o=IDLE_PATTERN, ready_o=0.
  - Lock loss has priority over retrain and over any handshake in the same cycle; no transfer counts that cycle.
  - word_cnt_o is kept through lock loss and cleared only by RSTB.
- Reset mid-operation: RSTB overrides everything, including an in-flight handshake; no transfer counts that cycle.
- Simultaneous events:
  - Priority is RSTB > lock loss > retrain > data transfer.
  - valid_i held with ready_o=0 is legal; data_i must stay stable until accepted.
- gear_d_o changes only on SCLK edges, so the gearbox sees stable D inputs for a full SCLK period.
- Counter widths: lock 8b, flush 4b, train 8b, word 16b wrapping (0xFFFF+1 -> 0x0000).

Test Plan:
1. Lock settling: RSTB 3 cycles, then lock_i=1 continuously -> gear_rst_o=1 through edge 15 after reset release, 0 at edge 16. state_o goes 1, then 2 four cycles later. gear_d_o=0xB4 for exactly 8 cycles, then state_o=3 and link_up_o=1.
2. Lock glitch in HOLD: lock_i=1 for 10 cycles, 0 for 1, then 1 -> release occurs 16 cycles after the glitch, not 6.
3. Streaming with bubbles: in RUN, offer 0x11, 0x22, gap, 0x33 with valid_i -> gear_d_o shows 0x11, 0x22, 0x00, 0x33 one cycle after each handshake; word_cnt_o=3.
4. Retrain with pending data: valid_i=1 with data 0x5A and retrain_i=1 in the same cycle -> ready_o=0, no transfer. 8 cycles of 0xB4 follow, then 0x5A is accepted in RUN; word_cnt_o increments by 1 only then.
5. Lock loss mid-stream: lock_i=0 in the same cycle as valid_i=1 -> next edge state_o=0, gear_rst_o=1, gear_d_o=0x00, word_cnt_o unchanged. Restoring lock repeats the full HOLD/FLUSH/TRAIN sequence.
6. Counter wrap: preload by streaming 65536 words -> word_cnt_o returns to 0x0000. RSTB mid-RUN -> every output returns to its reset value on the next edge.

Source files
------------

// File: rtl/oddrx4_tx_sequencer.sv
// SCLK-domain sequencer for an 8:1 DDR output gearbox: reset hold until lock,
// pipeline flush, training burst, then valid/ready streaming with idle fill.
module oddrx4_tx_sequencer #(
  parameter int unsigned LOCK_WAIT     = 16,
  parameter int unsigned FLUSH_CYCLES  = 4,
  parameter int unsigned TRAIN_WORDS   = 8,
  parameter logic [7:0]  TRAIN_PATTERN = 8'hB4,
  parameter logic [7:0]  IDLE_PATTERN  = 8'h00
) (
  input  logic        SCLK,
  input  logic        RSTB,
  input  logic        lock_i,
  input  logic        retrain_i,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        gear_rst_o,
  output logic [7:0]  gear_d_o,
  output logic [1:0]  state_o,
  output logic        link_up_o,
  output logic [15:0] word_cnt_o
);

  localparam int unsigned LOCK_W  = 8;
  localparam int unsigned FLUSH_W = 4;
  localparam int unsigned TRAIN_W = 8;
  localparam int unsigned WORD_W  = 16;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    FLUSH = 2'd1,
    TRAIN = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t              state;
  logic [LOCK_W-1:0]   lock_cnt;
  logic [FLUSH_W-1:0]  flush_cnt;
  logic [TRAIN_W-1:0]  train_cnt;
  logic                xfer;

  // Ready is offered combinationally so a handshake lands on the next edge.
  assign ready_o = (state == RUN) && !retrain_i;
  // Lock loss outranks the handshake, so a transfer also needs lock.
  assign xfer    = valid_i && ready_o && lock_i;
  assign state_o = state;

  always_ff @(posedge SCLK) begin
    if (RSTB) begin
      state      <= HOLD;
      gear_rst_o <= 1'b1;
      gear_d_o   <= IDLE_PATTERN;
      link_up_o  <= 1'b0;
      word_cnt_o <= '0;
      lock_cnt   <= '0;
      flush_cnt  <= '0;
      train_cnt  <= '0;
    end else if (state != HOLD && !lock_i) begin
      state      <= HOLD;
      gear_rst_o <= 1'b1;
      gear_d_o   <= IDLE_PATTERN;
      link_up_o  <= 1'b0;
      lock_cnt   <= '0;
    end else begin
      case (state)
        HOLD: begin
          gear_rst_o <= 1'b1;
          gear_d_o   <= IDLE_PATTERN;
          link_up_o  <= 1'b0;
          if (!lock_i) begin
            lock_cnt <= '0;
          end else if (lock_cnt == LOCK_W'(LOCK_WAIT - 1)) begin
            state      <= FLUSH;
            gear_rst_o <= 1'b0;
            lock_cnt   <= '0;
            flush_cnt  <= '0;
          end else begin
            lock_cnt <= lock_cnt + LOCK_W'(1);
          end
        end
        FLUSH: begin
          gear_d_o <= IDLE_PATTERN;
          if (flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1)) begin
            state     <= TRAIN;
            train_cnt <= '0;
            gear_d_o  <= TRAIN_PATTERN;
          end else begin
            flush_cnt <= flush_cnt + FLUSH_W'(1);
          end
        end
        TRAIN: begin
          if (train_cnt == TRAIN_W'(TRAIN_WORDS - 1)) begin
            state     <= RUN;
            link_up_o <= 1'b1;
            gear_d_o  <= IDLE_PATTERN;
          end else begin
            train_cnt <= train_cnt + TRAIN_W'(1);
            gear_d_o  <= TRAIN_PATTERN;
          end
        end
        RUN: begin
          if (retrain_i) begin
            state     <= TRAIN;
            train_cnt <= '0;
            link_up_o <= 1'b0;
            gear_d_o  <= TRAIN_PATTERN;
          end else if (xfer) begin
            gear_d_o   <= data_i;
            word_cnt_o <= word_cnt_o + WORD_W'(1);
          end else begin
            gear_d_o <= IDLE_PATTERN;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule
